// File: rtl/post_adder_acc.sv
// Post-adder/accumulator of a DSP48A1-style slice: X/Z operand muxes, add/subtract with carry-in,
// registered 48-bit result and carry-out with optional combinational bypass on the outputs.
module post_adder_acc #(
   parameter int PREG        = 1,
   parameter int CARRYOUTREG = 1
) (
   input  logic        CLK,
   input  logic        RSTP,
   input  logic        CEP,
   input  logic [7:0]  OPMODE,
   input  logic [35:0] M,
   input  logic [17:0] D,
   input  logic [17:0] A,
   input  logic [17:0] B,
   input  logic [47:0] C,
   input  logic [47:0] PCIN,
   input  logic        CIN,
   output logic [47:0] P,
   output logic [47:0] PCOUT,
   output logic        CARRYOUT,
   output logic        CARRYOUTF
);

   logic [47:0] p_q, p_d;
   logic        co_q, co_d;
   logic [47:0] x_mux, z_mux;
   logic [48:0] sum;

   // OPMODE[6:4] belongs to the pre-adder stage and D[17:12] never reaches the concatenation.
   logic unused_bits;
   assign unused_bits = ^{OPMODE[6:4], D[17:12]};

   // Feedback always taps the internal register, so PREG=0 cannot create a combinational loop.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      x_mux = 48'd0;
      case (OPMODE[1:0])
         2'd0: x_mux = 48'd0;
         2'd1: x_mux = {12'd0, M};
         2'd2: x_mux = p_q;
         2'd3: x_mux = {D[11:0], A, B};
         default: x_mux = 48'd0;
      endcase
   end

   always_comb begin
      z_mux = 48'd0;
      case (OPMODE[3:2])
         2'd0: z_mux = 48'd0;
         2'd1: z_mux = PCIN;
         2'd2: z_mux = p_q;
         2'd3: z_mux = C;
         default: z_mux = 48'd0;
      endcase
   end

   // 49-bit arithmetic; when subtracting, sum[48] is the borrow.
   always_comb begin
      if (OPMODE[7]) begin
         sum = {1'b0, z_mux} - ({1'b0, x_mux} + {48'd0, CIN});
      end else begin
         sum = {1'b0, z_mux} + {1'b0, x_mux} + {48'd0, CIN};
      end
   end

   always_comb begin
      p_d  = p_q;
      co_d = co_q;
      if (RSTP) begin
         p_d  = 48'd0;
         co_d = 1'b0;
      end else if (CEP) begin
         p_d  = sum[47:0];
         co_d = sum[48];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge CLK) begin
      p_q  <= p_d;
      co_q <= co_d;
   end

   assign P         = (PREG != 0)        ? p_q  : sum[47:0];
   assign CARRYOUT  = (CARRYOUTREG != 0) ? co_q : sum[48];
   assign PCOUT     = P;
   assign CARRYOUTF = CARRYOUT;

endmodule

// File: tb/tb_post_adder_acc.sv
// Directed bench: a registered instance driven from a vector table, plus a bypass instance
// sharing the same inputs for same-cycle checks.
module tb_post_adder_acc;

   logic        clk = 1'b0;
   logic        rstp, cep, cin;
   logic [7:0]  opmode;
   logic [35:0] m;
   logic [17:0] d, a, b;
   logic [47:0] c, pcin;

   logic [47:0] p_r, pcout_r, p_c, pcout_c;
   logic        co_r, cof_r, co_c, cof_c;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   post_adder_acc #(.PREG(1), .CARRYOUTREG(1)) u_reg (
      .CLK(clk), .RSTP(rstp), .CEP(cep), .OPMODE(opmode), .M(m), .D(d), .A(a), .B(b),
      .C(c), .PCIN(pcin), .CIN(cin), .P(p_r), .PCOUT(pcout_r), .CARRYOUT(co_r), .CARRYOUTF(cof_r)
   );

   post_adder_acc #(.PREG(0), .CARRYOUTREG(0)) u_comb (
      .CLK(clk), .RSTP(rstp), .CEP(cep), .OPMODE(opmode), .M(m), .D(d), .A(a), .B(b),
      .C(c), .PCIN(pcin), .CIN(cin), .P(p_c), .PCOUT(pcout_c), .CARRYOUT(co_c), .CARRYOUTF(cof_c)
   );

   typedef struct {
      string       name;
      logic        rstp;
      logic        cep;
      logic [7:0]  opmode;
      logic [35:0] m;
      logic [17:0] d, a, b;
      logic [47:0] c, pcin;
      logic        cin;
      logic [47:0] exp_p;
      logic        exp_co;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rstp = v.rstp; cep = v.cep; opmode = v.opmode; m = v.m; d = v.d; a = v.a; b = v.b;
      c = v.c; pcin = v.pcin; cin = v.cin;
   endtask

   function automatic vec_t mk(input string name, input logic r, input logic ce, input logic [7:0] op,
                               input logic [35:0] mm, input logic [47:0] cc, input logic ci,
                               input logic [47:0] ep, input logic eco);
      vec_t v;
      v.name = name; v.rstp = r; v.cep = ce; v.opmode = op; v.m = mm; v.c = cc; v.cin = ci;
      v.d = 18'd0; v.a = 18'd0; v.b = 18'd0; v.pcin = 48'd0; v.exp_p = ep; v.exp_co = eco;
      return v;
   endfunction

   initial begin
      vec_t v;
      rstp = 1'b1; cep = 1'b1; cin = 1'b1; opmode = 8'h0D; m = 36'd5; c = 48'd10;
      d = 18'd0; a = 18'd0; b = 18'd0; pcin = 48'd0;

      vecs.push_back(mk("reset",      1, 1, 8'h0D, 36'd5, 48'd10, 1, 48'd0, 0));
      vecs.push_back(mk("add",        0, 1, 8'h0D, 36'd5, 48'd10, 1, 48'd16, 0));
      vecs.push_back(mk("reset2",     1, 1, 8'h09, 36'd3, 48'd0, 0, 48'd0, 0));
      vecs.push_back(mk("acc1",       0, 1, 8'h09, 36'd3, 48'd0, 0, 48'd3, 0));
      vecs.push_back(mk("acc2",       0, 1, 8'h09, 36'd3, 48'd0, 0, 48'd6, 0));
      vecs.push_back(mk("acc3",       0, 1, 8'h09, 36'd3, 48'd0, 0, 48'd9, 0));
      vecs.push_back(mk("acc4",       0, 1, 8'h09, 36'd3, 48'd0, 0, 48'd12, 0));
      vecs.push_back(mk("hold1",      0, 0, 8'h09, 36'd3, 48'd0, 0, 48'd12, 0));
      vecs.push_back(mk("hold2",      0, 0, 8'h09, 36'd3, 48'd0, 0, 48'd12, 0));
      vecs.push_back(mk("mid_reset",  1, 1, 8'h09, 36'd3, 48'd0, 0, 48'd0, 0));
      vecs.push_back(mk("resume",     0, 1, 8'h09, 36'd3, 48'd0, 0, 48'd3, 0));
      vecs.push_back(mk("overflow",   0, 1, 8'h0D, 36'd1, 48'hFFFF_FFFF_FFFF, 0, 48'd0, 1));
      vecs.push_back(mk("borrow",     0, 1, 8'h8D, 36'd7, 48'd5, 0, 48'hFFFF_FFFF_FFFE, 1));
      vecs.push_back(mk("sub_cin",    0, 1, 8'h8D, 36'd4, 48'd9, 1, 48'd4, 0));
      vecs.push_back(mk("dec1",       0, 1, 8'h89, 36'd1, 48'd0, 1, 48'd2, 0));
      vecs.push_back(mk("dec2",       0, 1, 8'h89, 36'd1, 48'd0, 1, 48'd0, 0));
      vecs.push_back(mk("dec_under",  0, 1, 8'h89, 36'd1, 48'd0, 1, 48'hFFFF_FFFF_FFFE, 1));
      vecs.push_back(mk("x_is_p",     0, 1, 8'h02, 36'd9, 48'd9, 0, 48'hFFFF_FFFF_FFFE, 0));
      v = mk("z_pcin", 0, 1, 8'h04, 36'd9, 48'd9, 1, 48'd124, 0);
      v.pcin = 48'd123;
      vecs.push_back(v);
      v = mk("concat", 0, 1, 8'h73, 36'd9, 48'd9, 0, 48'hABC4_8D16_0001, 0);
      v.d = 18'h3FABC; v.a = 18'h12345; v.b = 18'h20001;
      vecs.push_back(v);
      vecs.push_back(mk("rst_no_cep", 1, 0, 8'h0D, 36'd5, 48'd10, 0, 48'd0, 0));

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i]);
         @(posedge clk);
         #1;
         check({vecs[i].name, ".P"},         p_r,             vecs[i].exp_p);
         check({vecs[i].name, ".PCOUT"},     pcout_r,         vecs[i].exp_p);
         check({vecs[i].name, ".CARRYOUT"},  {47'd0, co_r},   {47'd0, vecs[i].exp_co});
         check({vecs[i].name, ".CARRYOUTF"}, {47'd0, cof_r},  {47'd0, vecs[i].exp_co});
      end

      // Bypass instance: outputs follow the sum before any edge, even under reset.
      @(negedge clk);
      rstp = 1'b1; cep = 1'b1; opmode = 8'h0D; m = 36'd5; c = 48'd10; cin = 1'b1;
      #1;
      check("comb_in_reset.P", p_c, 48'd16);

      @(negedge clk);
      rstp = 1'b0; opmode = 8'h07; d = 18'h001; a = 18'd0; b = 18'd1; pcin = 48'd1; cin = 1'b0;
      #1;
      check("comb_concat.P",        p_c,            48'h0010_0000_0002);
      check("comb_concat.PCOUT",    pcout_c,        48'h0010_0000_0002);
      check("comb_concat.CARRYOUT", {47'd0, co_c},  48'd0);

      opmode = 8'h0D; m = 36'd1; c = 48'hFFFF_FFFF_FFFF; cin = 1'b0;
      #1;
      check("comb_ovf.P",         p_c,            48'd0);
      check("comb_ovf.CARRYOUT",  {47'd0, co_c},  48'd1);
      check("comb_ovf.CARRYOUTF", {47'd0, cof_c}, 48'd1);

      // Feedback in bypass mode comes from the internal register.
      rstp = 1'b1;
      @(negedge clk);
      rstp = 1'b0; opmode = 8'h09; m = 36'd3; cin = 1'b0;
      #1;
      check("comb_fb0.P", p_c, 48'd3);
      @(negedge clk);
      #1;
      check("comb_fb1.P", p_c, 48'd6);
      check("comb_fb1.reg_P", p_r, 48'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/post_adder_acc.md
Name: post_adder_acc

Overview:
- Downstream neighbour of the carry-in stage in the DSP48A1 slice. It consumes the registered carry-in (CIN) and the multiplier product (M).
- Selects the X and Z operands through OPMODE-controlled muxes, then adds or subtracts them with the carry-in.
- Registers the 48-bit result (P) and the carry-out (CARRYOUT), and forwards them to the cascade and fabric outputs.
- Feeding P back through the muxes makes the block an accumulator.

Parameters:
PREG, 1, 1 = P output taken from the P register; 0 = P output taken combinationally from the post-adder.
CARRYOUTREG, 1, 1 = CARRYOUT/CARRYOUTF taken from the carry register; 0 = taken combinationally.

Ports:
CLK  input  1  single clock; all state updates on the rising edge.
RSTP  input  1  synchronous, active-high reset of the P register and the carry-out register.
CEP  input  1  clock enable for the P register and the carry-out register.
OPMODE  input  8  [1:0] X select, [3:2] Z select, [7] 0 = add / 1 = subtract; [6:4] ignored by this block.
M  input  36  multiplier product.
D  input  18  D port; only [11:0] is used.
A  input  18  A port.
B  input  18  B port.
C  input  48  C port.
PCIN  input  48  P cascade input.
CIN  input  1  carry-in from the carry-in stage.
P  output  48  post-adder result.
PCOUT  output  48  cascade output; always equal to P.
CARRYOUT  output  1  carry/borrow out of the post-adder.
CARRYOUTF  output  1  fabric copy; always equal to CARRYOUT.

Behaviour:
- X mux, OPMODE[1:0]:
  - 0: 48'd0.
  - 1: M zero-extended to 48 bits.
  - 2: P_int.
  - 3: {D[11:0], A, B}.
- Z mux, OPMODE[3:2]:
  - 0: 48'd0.
  - 1: PCIN.
  - 2: P_int.
  - 3: C.
- P_int is the internal P register. Feedback always comes from P_int, even when PREG=0, so there is never a combinational loop.
- Arithmetic, computed in 49 bits:
  - OPMODE[7]=0: S = {0,Z} + {0,X} + CIN.
  - OPMODE[7]=1: S = {0,Z} − ({0,X} + CIN).
  - Result = S[47:0]; carry = S[48].
  - When subtracting, carry = 1 means borrow (the result is negative); all arithmetic is modulo 2^49.
- Register update on each rising CLK edge, in priority order:
  1. RSTP=1: P_int <= 0 and CO_int <= 0, regardless of CEP.
  2. Else if CEP=1: P_int <= S[47:0] and CO_int <= S[48].
  3. Else: both registers hold.
- These registers update identically for every parameter value. PREG and CARRYOUTREG select only the output source.
- Latency:
  - PREG=1: P appears 1 cycle after the inputs are applied.
  - PREG=0: P = S[47:0] in the same cycle.
  - CARRYOUTREG selects between CO_int and S[48] in the same way.
- Reset values:
  - P, PCOUT, CARRYOUT and CARRYOUTF are 0 after reset when their register option is 1.
  - When the register option is 0, these outputs track the combinational sum. After reset, that sum uses P_int=0 if P is selected as an operand.
- Accumulate behaviour: with Z=P_int (OPMODE[3:2]=2) and CEP held high, P_int grows by X+CIN (or shrinks by X+CIN when subtracting) every cycle.
- Wrap-around: overflow wraps modulo 2^48 with no saturation; the overflow is visible only on the carry.
- Simultaneous events:
  - A reset in the middle of an accumulation clears the accumulator on that edge.
  - On the next edge, accumulation resumes from 0.
- OPMODE, CIN and the data inputs are sampled on the same edge. No internal OPMODE register exists; the upstream stage provides it.

Test Plan:
1. Reset: RSTP=1 for 1 cycle with CEP=1 and nonzero inputs -> P=0, CARRYOUT=0, PCOUT=0.
2. Add, PREG=1: OPMODE=8'b0000_1101 (X=M, Z=C), M=5, C=10, CIN=1 -> P=16 one cycle later, CARRYOUT=0; PCOUT and CARRYOUTF mirror P and CARRYOUT.
3. Accumulate: after reset, OPMODE=8'b0000_1001 (X=M, Z=P), M=3, CIN=0, CEP=1 for 4 cycles -> P=3, 6, 9, 12. Drop CEP for 2 cycles -> P holds 12. Assert RSTP with CEP=1 -> P=0, and the next cycle gives P=3.
4. Overflow: X=M=1, Z=C=48'hFFFF_FFFF_FFFF, add, CIN=0 -> P=0, CARRYOUT=1.
5. Subtract/borrow: OPMODE=8'b1000_1101, C=5, M=7, CIN=0 -> P=48'hFFFF_FFFF_FFFE, CARRYOUT=1. With C=9, M=4, CIN=1 -> P=4, CARRYOUT=0.
6. Concat/cascade/bypass, PREG=0 and CARRYOUTREG=0: OPMODE=8'b0000_0111 (X={D,A,B}, Z=PCIN), D=12'h001, A=0, B=1, PCIN=1 -> P=48'h0010_0000_0002 in the same cycle, with no clock edge needed.
